// File: rtl/hmr_dmr_recovery_seq_if.sv
// Purpose: bundles the recovery handshake, core control and backup register-file
//          signals between the DMR control side and the recovery sequencer.
// Modports:
//   master : DMR control / cores / backup storage side (drives request, halted
//            status and backup RF read data)
//   slave  : recovery sequencer (drives all control, status and RF write signals)
// Signal names keep the sequencer's point of view (_i into it, _o out of it).
interface hmr_dmr_recovery_seq_if #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned RfAddrWidth = 5
);
    logic                   recovery_request_i;
    logic                   recovery_finished_o;
    logic                   recovery_active_o;
    logic                   instr_lock_o;
    logic                   debug_halt_o;
    logic [1:0]             cores_halted_i;
    logic [1:0]             setback_o;
    logic                   pc_recover_o;
    logic                   csr_recover_o;
    logic [RfAddrWidth-1:0] rf_raddr_o;
    logic [DataWidth-1:0]   rf_rdata_i;
    logic                   rf_we_o;
    logic [RfAddrWidth-1:0] rf_waddr_o;
    logic [DataWidth-1:0]   rf_wdata_o;
    logic                   halt_timeout_o;

    modport master (
        output recovery_request_i, cores_halted_i, rf_rdata_i,
        input  recovery_finished_o, recovery_active_o, instr_lock_o, debug_halt_o,
               setback_o, pc_recover_o, csr_recover_o, rf_raddr_o, rf_we_o,
               rf_waddr_o, rf_wdata_o, halt_timeout_o
    );

    modport slave (
        input  recovery_request_i, cores_halted_i, rf_rdata_i,
        output recovery_finished_o, recovery_active_o, instr_lock_o, debug_halt_o,
               setback_o, pc_recover_o, csr_recover_o, rf_raddr_o, rf_we_o,
               rf_waddr_o, rf_wdata_o, halt_timeout_o
    );
endinterface

// File: rtl/hmr_dmr_recovery_seq.sv
// Purpose: responder side of the DMR rapid-recovery handshake. On a recovery
//          request it halts the lockstep pair, sets both cores back, restores
//          PC, GPRs 1..NumRegs-1 and CSRs, then pulses recovery_finished_o.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous reset, active-high
//   bus    : slave modport of hmr_dmr_recovery_seq_if (request/finished handshake,
//            halt/setback/restore controls, backup RF read port, core RF write port,
//            sticky halt timeout flag)
// All control outputs come straight from flops; rf_wdata_o is the only
// combinational output (backup read data forwarded during the RF phase).
module hmr_dmr_recovery_seq #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned NumRegs     = 32,
    parameter int unsigned RfAddrWidth = 5,
    parameter int unsigned HaltTimeout = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    hmr_dmr_recovery_seq_if.slave bus
);

    localparam int unsigned TimerWidth = (HaltTimeout > 1) ? $clog2(HaltTimeout) : 1;
    localparam logic [TimerWidth-1:0]  TimerLast = TimerWidth'(HaltTimeout - 1);
    localparam logic [RfAddrWidth-1:0] RfFirst   = RfAddrWidth'(1);
    localparam logic [RfAddrWidth-1:0] RfLast    = RfAddrWidth'(NumRegs - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_SETBACK,
        ST_PC,
        ST_RF,
        ST_CSR,
        ST_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [TimerWidth-1:0]  timer_q, timer_d;
    logic [RfAddrWidth-1:0] rf_cnt_q, rf_cnt_d;
    logic                   timeout_q, timeout_d;
    logic                   finished_q, finished_d;
    logic                   active_q, active_d;
    logic                   lock_q, lock_d;
    logic                   halt_q, halt_d;
    logic [1:0]             setback_q, setback_d;
    logic                   pc_q, pc_d;
    logic                   csr_q, csr_d;
    logic                   we_q, we_d;

    // Next-state logic; outputs are decoded from the next state so they are
    // registered yet still line up with the state the FSM is in.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        rf_cnt_d  = '0;          // counter is zero outside RF, doubling as the address
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.recovery_request_i) begin
                    state_d   = ST_HALT;
                    timer_d   = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_HALT: begin
                timer_d = timer_q + TimerWidth'(1);
                if (bus.cores_halted_i == 2'b11) begin
                    state_d = ST_SETBACK;
                    timer_d = '0;
                end else if (timer_q == TimerLast) begin
                    // Give up waiting; restore anyway and flag it.
                    state_d   = ST_SETBACK;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                end
            end
            ST_SETBACK: state_d = ST_PC;
            ST_PC: begin
                state_d  = ST_RF;
                rf_cnt_d = RfFirst;  // x0 is never restored
            end
            ST_RF: begin
                if (rf_cnt_q == RfLast) begin
                    state_d = ST_CSR;
                end else begin
                    rf_cnt_d = rf_cnt_q + RfAddrWidth'(1);
                end
            end
            ST_CSR:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        active_d   = (state_d != ST_IDLE);
        lock_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
        halt_d     = (state_d == ST_HALT);
        setback_d  = {2{state_d == ST_SETBACK}};
        pc_d       = (state_d == ST_PC);
        csr_d      = (state_d == ST_CSR);
        we_d       = (state_d == ST_RF);
        finished_d = (state_d == ST_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            rf_cnt_q   <= '0;
            timeout_q  <= 1'b0;
            finished_q <= 1'b0;
            active_q   <= 1'b0;
            lock_q     <= 1'b0;
            halt_q     <= 1'b0;
            setback_q  <= 2'b00;
            pc_q       <= 1'b0;
            csr_q      <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rf_cnt_q   <= rf_cnt_d;
            timeout_q  <= timeout_d;
            finished_q <= finished_d;
            active_q   <= active_d;
            lock_q     <= lock_d;
            halt_q     <= halt_d;
            setback_q  <= setback_d;
            pc_q       <= pc_d;
            csr_q      <= csr_d;
            we_q       <= we_d;
        end
    end

    assign bus.recovery_finished_o = finished_q;
    assign bus.recovery_active_o   = active_q;
    assign bus.instr_lock_o        = lock_q;
    assign bus.debug_halt_o        = halt_q;
    assign bus.setback_o           = setback_q;
    assign bus.pc_recover_o        = pc_q;
    assign bus.csr_recover_o       = csr_q;
    assign bus.rf_raddr_o          = rf_cnt_q;
    assign bus.rf_waddr_o          = rf_cnt_q;
    assign bus.rf_we_o             = we_q;
    // Backup read data goes straight through to both cores while restoring.
    assign bus.rf_wdata_o          = we_q ? bus.rf_rdata_i : {DataWidth{1'b0}};
    assign bus.halt_timeout_o      = timeout_q;

endmodule

// File: tb/tb_hmr_dmr_recovery_seq.sv
// Purpose: self-checking bench for hmr_dmr_recovery_seq. Every cycle of each
//          recovery is compared against a phase model derived from cycle offsets
//          relative to request acceptance; RF writes are also tallied per address.
module tb_hmr_dmr_recovery_seq;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned HT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hmr_dmr_recovery_seq_if #(.DataWidth(DW), .RfAddrWidth(AW)) bus ();

    hmr_dmr_recovery_seq #(
        .DataWidth(DW), .NumRegs(NR), .RfAddrWidth(AW), .HaltTimeout(HT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    // Backup register file: combinational read.
    logic [DW-1:0] mem [NR];
    assign bus.rf_rdata_i = mem[bus.rf_raddr_o];

    int   n_checks = 0;
    int   n_errors = 0;
    int   wr_cnt [NR];
    logic exp_timeout = 1'b0;

    typedef struct packed {
        logic          fin;
        logic          act;
        logic          lock;
        logic          halt;
        logic [1:0]    sb;
        logic          pc;
        logic          csr;
        logic [AW-1:0] raddr;
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          tmo;
    } obs_t;

    function automatic obs_t observe();
        obs_t o;
        o.fin   = bus.recovery_finished_o;
        o.act   = bus.recovery_active_o;
        o.lock  = bus.instr_lock_o;
        o.halt  = bus.debug_halt_o;
        o.sb    = bus.setback_o;
        o.pc    = bus.pc_recover_o;
        o.csr   = bus.csr_recover_o;
        o.raddr = bus.rf_raddr_o;
        o.we    = bus.rf_we_o;
        o.waddr = bus.rf_waddr_o;
        o.wdata = bus.rf_wdata_o;
        o.tmo   = bus.halt_timeout_o;
        return o;
    endfunction

    function automatic obs_t idle_exp(input logic tmo);
        obs_t e;
        e = '0;
        e.tmo = tmo;
        return e;
    endfunction

    // Expected outputs k cycles after the accepting IDLE cycle, given h cycles in HALT.
    function automatic obs_t model(input int k, input int h, input logic tmo_after);
        obs_t e;
        int   a;
        e = '0;
        if (k <= h) begin
            e.act = 1'b1; e.lock = 1'b1; e.halt = 1'b1;
        end else begin
            e.tmo = tmo_after;
            if (k == h + 1) begin
                e.act = 1'b1; e.lock = 1'b1; e.sb = 2'b11;
            end else if (k == h + 2) begin
                e.act = 1'b1; e.lock = 1'b1; e.pc = 1'b1;
            end else if (k >= h + 3 && k <= h + int'(NR) + 1) begin
                a = k - h - 2;
                e.act = 1'b1; e.lock = 1'b1; e.we = 1'b1;
                e.raddr = AW'(a);
                e.waddr = AW'(a);
                e.wdata = mem[a];
            end else if (k == h + int'(NR) + 2) begin
                e.act = 1'b1; e.lock = 1'b1; e.csr = 1'b1;
            end else if (k == h + int'(NR) + 3) begin
                e.act = 1'b1; e.fin = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input string name);
        bus.recovery_request_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            bus.cores_halted_i = 2'($urandom_range(0, 3));
            check($sformatf("%s idle%0d", name, i), observe(), idle_exp(exp_timeout));
        end
    endtask

    task automatic fill_pattern();
        for (int a = 0; a < int'(NR); a++) mem[a] = 32'hA500_0000 | DW'(a);
    endtask

    task automatic fill_random();
        for (int a = 0; a < int'(NR); a++) mem[a] = $urandom;
    endtask

    // One full recovery. Entered during the cycle before the accepting IDLE cycle;
    // returns during the DONE cycle. halt_k: cycle at which both cores report halted.
    task automatic run_seq(input int halt_k, input logic [1:0] pre_halt, input bit rand_pre,
                           input bit hold_req, input int drop_k, input string name);
        int   h;
        logic tmo;
        int   done_k;
        int   drop;
        h      = (halt_k <= int'(HT)) ? halt_k : int'(HT);
        tmo    = (halt_k > int'(HT));
        done_k = h + int'(NR) + 3;
        drop   = (drop_k <= 0 || drop_k > done_k) ? done_k : drop_k;
        for (int a = 0; a < int'(NR); a++) wr_cnt[a] = 0;

        step();
        check({name, " accept-idle"}, observe(), idle_exp(exp_timeout));
        bus.recovery_request_i = 1'b1;
        bus.cores_halted_i     = 2'b00;
        for (int k = 1; k <= done_k; k++) begin
            step();
            if (k <= h) begin
                if (k >= halt_k)  bus.cores_halted_i = 2'b11;
                else if (rand_pre) bus.cores_halted_i = 2'($urandom_range(0, 2));
                else               bus.cores_halted_i = pre_halt;
            end else begin
                bus.cores_halted_i = 2'($urandom_range(0, 3));
            end
            bus.recovery_request_i = hold_req ? 1'b1 : (k < drop);
            check($sformatf("%s k=%0d", name, k), observe(), model(k, h, tmo));
            if (bus.rf_we_o) wr_cnt[bus.rf_waddr_o]++;
        end
        exp_timeout = tmo;
        for (int a = 0; a < int'(NR); a++)
            check_int($sformatf("%s writes@%0d", name, a), wr_cnt[a], (a == 0) ? 0 : 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.recovery_request_i = 1'b1;
        bus.cores_halted_i     = 2'b11;
        fill_pattern();

        // Outputs stay low while reset is held, even with a request pending.
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("reset_held%0d", i), observe(), idle_exp(1'b0));
        end
        bus.recovery_request_i = 1'b0;
        rst = 1'b0;
        idle_cycles(10, "post_reset");

        // Directed: halted after two HALT cycles, A5 data pattern.
        run_seq(2, 2'b00, 1'b0, 1'b0, 0, "directed");
        idle_cycles(2, "after_directed");

        // Cores never both halt: timeout after HT cycles, flag sticky in IDLE.
        run_seq(1000, 2'b01, 1'b0, 1'b0, 0, "timeout");
        idle_cycles(4, "sticky_tmo");

        // Back-to-back with the request held high through finished.
        fill_random();
        run_seq(3, 2'b10, 1'b0, 1'b1, 0, "b2b_a");
        run_seq(3, 2'b10, 1'b0, 1'b1, 0, "b2b_b");
        run_seq(HT, 2'b00, 1'b0, 1'b0, 5, "halt_at_limit");
        idle_cycles(1, "after_b2b");

        // Randomized sequences: halt arrival, data, request drop point, chaining.
        for (int i = 0; i < 6; i++) begin
            bit hold;
            fill_random();
            hold = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_seq(int'($urandom_range(1, 20)), 2'b00, 1'b1, hold,
                    int'($urandom_range(1, 50)), $sformatf("rand%0d", i));
            if (!hold) idle_cycles(int'($urandom_range(0, 3)), $sformatf("rand_gap%0d", i));
        end

        // Reset during RF restore at address 12 aborts with no residue.
        fill_random();
        step();
        check("rst_seq accept-idle", observe(), idle_exp(exp_timeout));
        bus.recovery_request_i = 1'b1;
        bus.cores_halted_i     = 2'b00;
        for (int k = 1; k <= 15; k++) begin
            step();
            bus.cores_halted_i = 2'b11;
            check($sformatf("rst_seq k=%0d", k), observe(), model(k, 1, 1'b0));
        end
        rst = 1'b1;
        exp_timeout = 1'b0;
        #1;
        check("rst_async", observe(), idle_exp(1'b0));
        step();
        check("rst_edge", observe(), idle_exp(1'b0));
        bus.recovery_request_i = 1'b0;
        rst = 1'b0;
        idle_cycles(20, "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
